// File: rtl/inst_encoder.sv
// Instruction-field encoder for program loading: packs (op, rd, rs, imm) tuples into
// 16-bit words, buffers them in a small FIFO and streams them to the IMEM write port.
module inst_encoder #(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_fmt,
  input  logic [4:0]        in_op,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs,
  input  logic [7:0]        in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              err_imm,
  output logic              err_wrap,
  output logic              done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t         state;
  logic [15:0]    mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;

  logic        empty;
  logic        full;
  logic        accept;
  logic        imm_bad;
  logic        push;
  logic        pop;
  logic [15:0] word;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign in_ready = (state == LOAD) && !full;
  assign accept   = in_valid && in_ready;
  assign imm_bad  = !in_fmt && (in_imm[7:5] != 3'b000);
  assign push     = accept && !imm_bad;

  assign imem_we    = !empty;
  assign pop        = imem_we && imem_ready;
  assign imem_wdata = empty ? 16'h0000 : mem[rd_ptr[PTR_W-1:0]];

  assign word = in_fmt ? {in_imm, in_rd, in_op}
                       : {in_imm[4:0], in_rs, in_rd, in_op};

  // NOTE: the storage array has no reset; stale entries are never visible because
  // imem_wdata is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= word;
  end

  // NOTE: all sequential state uses non-blocking assignments so every block sees
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_addr  <= BASE;
      word_count <= '0;
      err_imm    <= 1'b0;
      err_wrap   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (pop) begin
        imem_addr  <= imem_addr + 1'b1;
        word_count <= word_count + 1'b1;
        if (imem_addr == {ADDR_W{1'b1}}) err_wrap <= 1'b1;
      end

      if (accept && imm_bad) err_imm <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            imem_addr  <= BASE;
            word_count <= '0;
            err_imm    <= 1'b0;
            err_wrap   <= 1'b0;
          end
        end
        LOAD: begin
          if (accept && in_last) state <= FLUSH;
        end
        FLUSH: begin
          // Session ends only once every queued word has reached IMEM.
          if (empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
